// File: rtl/leds_driver.sv
// Five-LED board driver: d1 is an always-on indicator; d2..d5 show off / all-on / chaser / PWM by mode.
// Optional LEDS_HEARTBEAT_EN turns d1 into a 16-tick-period heartbeat.
module leds_driver #(
  parameter int TICK_DIV = 10,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic                v6c86ce,
  output logic [3:0]          led_o
);

  localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);

  logic [15:0]         pre;
  logic                tick;
  logic [3:0]          pos;
  logic [3:0]          pos_next;
  logic [PWM_BITS-1:0] pwm;
  logic [1:0]          mode_prev;
  logic                pwm_on;

  assign tick   = (pre == PRE_MAX);
  assign pwm_on = (pwm < duty);

  // Entering chaser mode reloads 0001 and suppresses a coincident rotation.
  always_comb begin
    pos_next = pos;
    if (mode == 2'd2) begin
      if (mode_prev != 2'd2)
        pos_next = 4'b0001;
      else if (tick)
        pos_next = {pos[2:0], pos[3]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= 16'd0;
      pos       <= 4'b0001;
      pwm       <= '0;
      mode_prev <= 2'd0;
      led_o     <= 4'b0000;
    end else begin
      pre       <= tick ? 16'd0 : pre + 16'd1;
      pos       <= pos_next;
      pwm       <= pwm + PWM_BITS'(1);
      mode_prev <= mode;
      case (mode)
        2'd0:    led_o <= 4'b0000;
        2'd1:    led_o <= 4'b1111;
        2'd2:    led_o <= pos_next;
        default: led_o <= {4{pwm_on}};
      endcase
    end
  end

`ifdef LEDS_HEARTBEAT_EN
  logic [2:0] hb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt  <= 3'd0;
      v6c86ce <= 1'b0;
    end else if (tick) begin
      hb_cnt <= hb_cnt + 3'd1;
      if (hb_cnt == 3'd7)
        v6c86ce <= ~v6c86ce;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      v6c86ce <= 1'b0;
    else
      v6c86ce <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_leds_driver.sv
// Scoreboard bench for leds_driver: expected LED words are queued as each cycle is driven
// and popped once the registered output appears after the clock edge.
module tb_leds_driver;

  localparam int TICK_DIV = 10;
  localparam int PWM_BITS = 4;

  logic                clk;
  logic                rst_n;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] duty;
  logic                v6c86ce;
  logic [3:0]          led_o;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];
  int         n_edge;
  logic [1:0] prev_m;
  logic [3:0] chase;

  leds_driver #(.TICK_DIV(TICK_DIV), .PWM_BITS(PWM_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .duty(duty),
    .v6c86ce(v6c86ce), .led_o(led_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge n counts clock edges since reset release: prescaler is (n-1)%TICK_DIV before it,
  // so a tick lands on every edge with n%TICK_DIV==0; pwm before edge n is (n-1)%16.
  task automatic predict(output logic [3:0] e);
    int n;
    n = n_edge + 1;
    case (mode)
      2'd0: e = 4'b0000;
      2'd1: e = 4'b1111;
      2'd2: begin
        if (prev_m != 2'd2) chase = 4'b0001;
        else if (n % TICK_DIV == 0) chase = {chase[2:0], chase[3]};
        e = chase;
      end
      default: e = (((n - 1) % (1 << PWM_BITS)) < int'(duty)) ? 4'b1111 : 4'b0000;
    endcase
    prev_m = mode;
  endtask

  function automatic logic exp_ind(input int n);
`ifdef LEDS_HEARTBEAT_EN
    return logic'((n / (8 * TICK_DIV)) % 2);
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    n_edge++;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    n_edge = 0;
    prev_m = 2'd0;
    chase  = 4'b0001;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    logic [3:0] got_e;
    rst_n = 1'b0;
    mode  = 2'd0;
    duty  = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (led_o !== 4'b0000 || v6c86ce !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: led_o=%b ind=%b want led_o=0000 ind=0", led_o, v6c86ce);
    end
    release_reset();
    for (int i = 0; i < 10; i++) begin
      predict(e);
      exp_q.push_back(e);
      step();
      got_e = exp_q.pop_front();
      total++;
      if (led_o !== got_e || v6c86ce !== exp_ind(n_edge)) begin
        bad++;
        $display("FAIL reset_release edge %0d: led_o=%b ind=%b want led_o=%b ind=%b",
                 n_edge, led_o, v6c86ce, got_e, exp_ind(n_edge));
      end
    end
  endtask

  task automatic test_all_on();
    logic [3:0] e;
    logic [3:0] got_e;
    for (int i = 0; i < 6; i++) begin
      mode = (i < 3) ? 2'd1 : 2'd0;
      predict(e);
      exp_q.push_back(e);
      step();
      got_e = exp_q.pop_front();
      total++;
      if (led_o !== got_e || v6c86ce !== exp_ind(n_edge)) begin
        bad++;
        $display("FAIL all_on step %0d: led_o=%b ind=%b want led_o=%b ind=%b",
                 i, led_o, v6c86ce, got_e, exp_ind(n_edge));
      end
    end
  endtask

  task automatic test_chaser();
    logic [3:0] e;
    logic [3:0] got_e;
    int changes;
    logic [3:0] last;
    changes = 0;
    last = led_o;
    for (int i = 0; i < 60; i++) begin
      if (i < 42)      mode = 2'd2;
      else if (i < 45) mode = 2'd1;
      else             mode = 2'd2;
      predict(e);
      exp_q.push_back(e);
      step();
      got_e = exp_q.pop_front();
      total++;
      if (led_o !== got_e) begin
        bad++;
        $display("FAIL chaser step %0d mode %0d: led_o=%b want %b", i, mode, led_o, got_e);
      end
      if (i > 0 && i < 42 && led_o !== last) changes++;
      last = led_o;
    end
    // 41 cycles after the reload cover four ticks at a 10-cycle rate.
    total++;
    if (changes !== 4) begin
      bad++;
      $display("FAIL chaser_rate: changes=%0d want 4", changes);
    end
  endtask

  task automatic test_pwm();
    logic [3:0] e;
    logic [3:0] got_e;
    int on_cnt;
    int duties[3] = '{4, 0, 15};
    mode = 2'd3;
    foreach (duties[k]) begin
      duty = PWM_BITS'(duties[k]);
      predict(e);
      exp_q.push_back(e);
      step();
      void'(exp_q.pop_front());
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        predict(e);
        exp_q.push_back(e);
        step();
        got_e = exp_q.pop_front();
        total++;
        if (led_o !== got_e) begin
          bad++;
          $display("FAIL pwm duty %0d edge %0d: led_o=%b want %b", duties[k], n_edge, led_o, got_e);
        end
        if (led_o === 4'b1111) on_cnt++;
      end
      total++;
      if (on_cnt !== duties[k]) begin
        bad++;
        $display("FAIL pwm_on_time duty %0d: on=%0d want %0d of 16", duties[k], on_cnt, duties[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] e;
    logic [3:0] got_e;
    int budget;
    mode = 2'd2;
    budget = 0;
    do begin
      predict(e);
      exp_q.push_back(e);
      step();
      got_e = exp_q.pop_front();
      total++;
      if (led_o !== got_e) begin
        bad++;
        $display("FAIL pre_reset_chaser edge %0d: led_o=%b want %b", n_edge, led_o, got_e);
      end
      budget++;
    end while (led_o !== 4'b0100 && budget < 40);
    total++;
    if (led_o !== 4'b0100) begin
      bad++;
      $display("FAIL reach_0100: led_o=%b want 0100 within 40 cycles", led_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (led_o !== 4'b0000 || v6c86ce !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: led_o=%b ind=%b want led_o=0000 ind=0", led_o, v6c86ce);
    end
    @(posedge clk);
    release_reset();
    for (int i = 0; i < 12; i++) begin
      predict(e);
      exp_q.push_back(e);
      step();
      got_e = exp_q.pop_front();
      total++;
      if (led_o !== got_e || v6c86ce !== exp_ind(n_edge)) begin
        bad++;
        $display("FAIL post_reset_chaser edge %0d: led_o=%b ind=%b want led_o=%b ind=%b",
                 n_edge, led_o, v6c86ce, got_e, exp_ind(n_edge));
      end
    end
  endtask

  task automatic test_indicator_long();
    logic [3:0] e;
    logic [3:0] got_e;
    mode = 2'd1;
    for (int i = 0; i < 180; i++) begin
      predict(e);
      exp_q.push_back(e);
      step();
      got_e = exp_q.pop_front();
      total++;
      if (led_o !== got_e || v6c86ce !== exp_ind(n_edge)) begin
        bad++;
        $display("FAIL indicator edge %0d: led_o=%b ind=%b want led_o=%b ind=%b",
                 n_edge, led_o, v6c86ce, got_e, exp_ind(n_edge));
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    mode   = 2'd0;
    duty   = '0;
    n_edge = 0;
    prev_m = 2'd0;
    chase  = 4'b0001;
    test_reset();
    test_all_on();
    test_chaser();
    test_pwm();
    test_async_reset();
    test_indicator_long();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
